// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, default line
// configuration and the clocks-per-bit helper.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF = 50_000_000;
  localparam int unsigned BAUD_DEF     = 9600;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line plus an edge register;
// flags a falling edge of the synchronised line.
module uart_rx_sync (
  input  logic sclk,
  input  logic reset,
  input  logic rx,
  output logic rx_line,
  output logic rx_fall
);

  logic meta;
  logic sync;
  logic prev;

  // Flops reset to the idle (high) level so reset never fakes a start edge.
  always_ff @(posedge sclk) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rx;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rx_line = sync;
  assign rx_fall = prev & ~sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit detection on a falling edge, mid-bit sampling,
// one-cycle rx_done / frame_err strobes. Define UART_RX_PARITY_EN for 8E1 framing.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
  parameter int unsigned BAUD     = BAUD_DEF
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       RS232_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int unsigned BIT_CNT = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned HALF    = BIT_CNT / 2;
  localparam int unsigned CNT_W   = $clog2(BIT_CNT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  uart_state_t      state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_line;
  logic             rx_fall;
`ifdef UART_RX_PARITY_EN
  logic             par_bit;
`endif

  uart_rx_sync u_sync (
    .sclk    (sclk),
    .reset   (reset),
    .rx      (RS232_rx),
    .rx_line (rx_line),
    .rx_fall (rx_fall)
  );

  always_ff @(posedge sclk) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rx_fall) begin
            state    <= START;
            baud_cnt <= '0;
            rx_busy  <= 1'b1;
          end
        end

        // Restarting the counter at mid-start puts every later sample mid-bit.
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (!rx_line) begin
              state <= DATA;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shift    <= {rx_line, shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            par_bit  <= rx_line;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (rx_line) begin
              rx_data <= shift;
              rx_done <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err <= ^{shift, par_bit};
`endif
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        // Line held low after a bad stop bit must not look like a new start.
        BREAK: begin
          if (rx_line) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx, run at 16 clocks per bit.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int unsigned BAUD     = 3_125_000;
  localparam int unsigned BIT_CNT  = 16;
  localparam int unsigned HALF     = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned LAT = 2 + HALF + 10 * BIT_CNT;
`else
  localparam int unsigned LAT = 2 + HALF + 9 * BIT_CNT;
`endif

  logic       sclk = 1'b0;
  logic       reset;
  logic       RS232_rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  always #10 sclk = ~sclk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .sclk      (sclk),
    .reset     (reset),
    .RS232_rx  (RS232_rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         done_cnt = 0;
  int         fe_cnt   = 0;
  int         both_cnt = 0;
  int         pe_cnt   = 0;
  int         busy_cnt = 0;
  int         done_at[$];
  logic [7:0] data_at[$];

  always @(negedge sclk) begin
    cyc <= cyc + 1;
    if (rx_done) begin
      done_cnt <= done_cnt + 1;
      done_at.push_back(cyc);
      data_at.push_back(rx_data);
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (rx_done && frame_err) both_cnt <= both_cnt + 1;
    if (rx_busy) busy_cnt <= busy_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt <= pe_cnt + (rx_done ? 1 : 100);
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    #1;
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic send_bit(input logic b);
    RS232_rx = b;
    wait_cyc(BIT_CNT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    send_bit(stop_bit);
  endtask

  int t0;
  int d0;
  int f0;
  int lat;
  int gap;

  initial begin
    reset    = 1'b1;
    RS232_rx = 1'b1;
    wait_cyc(3);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_done", 32'(rx_done), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_rx_busy", 32'(rx_busy), 32'h0);
    reset = 1'b0;
    wait_cyc(2 * BIT_CNT);
    check("idle_no_strobe", 32'(done_cnt + fe_cnt), 32'h0);

    // single frame 0xC3, latency to mid-stop-bit
    t0 = cyc;
    send_frame(8'hC3, 1'b1, 1'b0);
    wait_cyc(BIT_CNT);
    check("c3_done_count", 32'(done_cnt), 32'd1);
    check("c3_data", 32'(data_at[0]), 32'hC3);
    lat = done_at[0] - t0;
    check("c3_latency_window", 32'(lat >= int'(LAT) - 1 && lat <= int'(LAT) + 2), 32'd1);
    check("c3_rx_data_held", 32'(rx_data), 32'hC3);
    check("c3_no_frame_err", 32'(fe_cnt), 32'd0);
    check("c3_idle", 32'(rx_busy), 32'd0);

    // back-to-back frames, single stop bit, no gap
    d0 = done_cnt;
    send_frame(8'hC3, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_cyc(BIT_CNT);
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    check("b2b_first", 32'(data_at[d0]), 32'hC3);
    check("b2b_second", 32'(data_at[d0+1]), 32'h5A);
    gap = done_at[d0+1] - done_at[d0];
`ifdef UART_RX_PARITY_EN
    check("b2b_spacing", 32'(gap), 32'(11 * BIT_CNT));
`else
    check("b2b_spacing", 32'(gap), 32'(10 * BIT_CNT));
`endif

    // glitch shorter than half a bit
    d0 = done_cnt;
    f0 = fe_cnt;
    busy_cnt = 0;
    RS232_rx = 1'b0;
    wait_cyc(5);
    RS232_rx = 1'b1;
    wait_cyc(3 * BIT_CNT);
    check("glitch_no_done", 32'(done_cnt - d0), 32'd0);
    check("glitch_no_frame_err", 32'(fe_cnt - f0), 32'd0);
    check("glitch_busy_seen", 32'(busy_cnt >= 5 && busy_cnt <= int'(HALF) + 2), 32'd1);
    check("glitch_idle", 32'(rx_busy), 32'd0);

    // framing error after a good 0x3C, line held low three bit times
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_cyc(BIT_CNT);
    check("pre_fe_data", 32'(rx_data), 32'h3C);
    d0 = done_cnt;
    f0 = fe_cnt;
    send_frame(8'hA5, 1'b0, 1'b0);
    wait_cyc(2 * BIT_CNT);
    check("fe_pulse_once", 32'(fe_cnt - f0), 32'd1);
    check("fe_no_done", 32'(done_cnt - d0), 32'd0);
    check("fe_data_kept", 32'(rx_data), 32'h3C);
    check("fe_busy_while_low", 32'(rx_busy), 32'd1);
    RS232_rx = 1'b1;
    wait_cyc(5);
    check("fe_idle_after_high", 32'(rx_busy), 32'd0);
    wait_cyc(2 * BIT_CNT);

    // reset in the middle of data bit 4
    d0 = done_cnt;
    f0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    RS232_rx = 1'b0;
    wait_cyc(HALF);
    check("abort_busy_mid", 32'(rx_busy), 32'd1);
    reset    = 1'b1;
    RS232_rx = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    check("abort_busy_cleared", 32'(rx_busy), 32'd0);
    wait_cyc(3 * BIT_CNT);
    check("abort_no_strobes", 32'(done_cnt - d0 + fe_cnt - f0), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0);
    wait_cyc(BIT_CNT);
    check("after_abort_done", 32'(done_cnt - d0), 32'd1);
    check("after_abort_data", 32'(rx_data), 32'h81);

`ifdef UART_RX_PARITY_EN
    check("parity_clean_so_far", 32'(pe_cnt), 32'd0);
    d0 = done_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    wait_cyc(BIT_CNT);
    check("parity_err_with_done", 32'(pe_cnt), 32'd1);
    check("parity_done", 32'(done_cnt - d0), 32'd1);
    check("parity_data_updated", 32'(rx_data), 32'h07);
`endif

    check("done_fe_exclusive", 32'(both_cnt), 32'd0);
    check("total_frame_err", 32'(fe_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
